// File: rtl/hazard_forward_controller.sv
// -----------------------------------------------------------------------------
// hazard_forward_controller
//
// Purpose: operand forwarding and hazard detection between register-file read
// and execute. For every source operand the youngest in-flight writer of the
// same register (stage 0 = EX, youngest) supplies the operand; without a match
// the register-file data passes through. If the winning writer's result is not
// ready yet, a stall is raised. A small FSM supervises stall duration: it
// pulses resume after a stall ends and flags a sticky timeout once a stall has
// lasted MAX_STALL consecutive cycles (terminal until reset).
//
// Optional build macro: HAZARD_PERF_COUNTERS_EN adds saturating stall-cycle and
// forward-cycle counters together with their output ports.
//
// Ports:
//   clk                      clock, rising edge
//   reset                    synchronous active-high reset
//   source_index             NUM_SRC x 5-bit source register indices
//   source_data              NUM_SRC x XLEN register-file read data
//   destination_index        NUM_STAGES x 5-bit destination registers
//   destination_write_enable per-stage valid register write
//   destination_data_ready   per-stage result available
//   destination_data         NUM_STAGES x XLEN per-stage results
//   forward_data             resolved operands (combinational)
//   forward_hit              operand came from a stage (combinational)
//   stall                    hazard present (combinational)
//   resume                   registered one-cycle pulse after a stall ends
//   stall_timeout            registered sticky stall-timeout flag
//   stall_cycle_count        (macro only) saturating count of stall cycles
//   forward_count            (macro only) saturating count of forwarding cycles
// -----------------------------------------------------------------------------
module hazard_forward_controller #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned MAX_STALL  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SRC*5-1:0]       source_index,
   input  logic [NUM_SRC*XLEN-1:0]    source_data,
   input  logic [NUM_STAGES*5-1:0]    destination_index,
   input  logic [NUM_STAGES-1:0]      destination_write_enable,
   input  logic [NUM_STAGES-1:0]      destination_data_ready,
   input  logic [NUM_STAGES*XLEN-1:0] destination_data,
   output logic [NUM_SRC*XLEN-1:0]    forward_data,
   output logic [NUM_SRC-1:0]         forward_hit,
   output logic                       stall,
   output logic                       resume,
   output logic                       stall_timeout
`ifdef HAZARD_PERF_COUNTERS_EN
   ,
   output logic [31:0]                stall_cycle_count,
   output logic [31:0]                forward_count
`endif
);

   typedef enum logic [1:0] {StRun, StStall, StFault} state_e;

   localparam logic [7:0] MaxStallC = 8'(MAX_STALL);

   state_e            r_state;
   logic [7:0]        r_stall_counter;
   logic              r_resume;
   logic              r_stall_timeout;
   logic [NUM_SRC-1:0] w_src_hazard;

   // Scan oldest to youngest so the youngest match overwrites older ones; the
   // hazard flag follows the same winner, so an older ready stage can never
   // mask a younger stage that is still busy.
   always_comb begin
      forward_data = source_data;
      forward_hit  = '0;
      w_src_hazard = '0;
      for (int s = 0; s < int'(NUM_SRC); s++) begin
         for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            if (destination_write_enable[k] &&
                (source_index[s*5 +: 5] != 5'd0) &&
                (destination_index[k*5 +: 5] == source_index[s*5 +: 5])) begin
               forward_data[s*XLEN +: XLEN] = destination_data[k*XLEN +: XLEN];
               forward_hit[s]               = 1'b1;
               w_src_hazard[s]              = ~destination_data_ready[k];
            end
         end
      end
      stall = |w_src_hazard;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= StRun;
         r_stall_counter <= 8'd0;
         r_resume        <= 1'b0;
         r_stall_timeout <= 1'b0;
      end else begin
         r_resume <= 1'b0;
         unique case (r_state)
            StRun: begin
               if (stall) begin
                  r_stall_counter <= 8'd1;
                  // A one-cycle budget is exhausted by the very first stall cycle.
                  if (MaxStallC == 8'd1) begin
                     r_state         <= StFault;
                     r_stall_timeout <= 1'b1;
                  end else begin
                     r_state <= StStall;
                  end
               end
            end
            StStall: begin
               if (stall) begin
                  if (r_stall_counter + 8'd1 == MaxStallC) begin
                     r_state         <= StFault;
                     r_stall_timeout <= 1'b1;
                  end else begin
                     r_stall_counter <= r_stall_counter + 8'd1;
                  end
               end else begin
                  r_state         <= StRun;
                  r_stall_counter <= 8'd0;
                  r_resume        <= 1'b1;
               end
            end
            StFault: begin
               // Terminal until reset.
            end
            default: begin
               r_state <= StRun;
            end
         endcase
      end
   end

   assign resume        = r_resume;
   assign stall_timeout = r_stall_timeout;

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] r_stall_cycle_count;
   logic [31:0] r_forward_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycle_count <= 32'd0;
         r_forward_count     <= 32'd0;
      end else begin
         if (stall && (r_stall_cycle_count != 32'hFFFF_FFFF)) begin
            r_stall_cycle_count <= r_stall_cycle_count + 32'd1;
         end
         if (!stall && (|forward_hit) && (r_forward_count != 32'hFFFF_FFFF)) begin
            r_forward_count <= r_forward_count + 32'd1;
         end
      end
   end

   assign stall_cycle_count = r_stall_cycle_count;
   assign forward_count     = r_forward_count;
`endif

endmodule

// File: tb/tb_hazard_forward_controller.sv
module tb_hazard_forward_controller;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NSRC = 2;
   localparam int unsigned NSTG = 3;
   localparam int unsigned MAXS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    reset;
   logic [NSRC*5-1:0]       source_index;
   logic [NSRC*XLEN-1:0]    source_data;
   logic [NSTG*5-1:0]       destination_index;
   logic [NSTG-1:0]         destination_write_enable;
   logic [NSTG-1:0]         destination_data_ready;
   logic [NSTG*XLEN-1:0]    destination_data;
   logic [NSRC*XLEN-1:0]    forward_data;
   logic [NSRC-1:0]         forward_hit;
   logic                    stall;
   logic                    resume;
   logic                    stall_timeout;
`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0]             stall_cycle_count;
   logic [31:0]             forward_count;
`endif

   hazard_forward_controller #(
      .XLEN      (XLEN),
      .NUM_SRC   (NSRC),
      .NUM_STAGES(NSTG),
      .MAX_STALL (MAXS)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .source_index            (source_index),
      .source_data             (source_data),
      .destination_index       (destination_index),
      .destination_write_enable(destination_write_enable),
      .destination_data_ready  (destination_data_ready),
      .destination_data        (destination_data),
      .forward_data            (forward_data),
      .forward_hit             (forward_hit),
      .stall                   (stall),
      .resume                  (resume),
      .stall_timeout           (stall_timeout)
`ifdef HAZARD_PERF_COUNTERS_EN
      ,
      .stall_cycle_count       (stall_cycle_count),
      .forward_count           (forward_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: stall supervision expressed as the length of the
   // current run of consecutive stall cycles.
   int run_len   = 0;
   bit m_fault   = 1'b0;
   bit m_timeout = 1'b0;
   bit m_resume  = 1'b0;
`ifdef HAZARD_PERF_COUNTERS_EN
   longint m_scc = 0;
   longint m_fc  = 0;
`endif

   // Youngest writer of the requested register wins; x0 is never forwarded.
   function automatic void ref_fwd(input int s, output logic [XLEN-1:0] d,
                                   output logic h, output logic hz);
      logic [4:0] idx;
      idx = source_index[s*5 +: 5];
      d   = source_data[s*XLEN +: XLEN];
      h   = 1'b0;
      hz  = 1'b0;
      for (int k = 0; k < int'(NSTG); k++) begin
         if (!h && idx != 5'd0 && destination_write_enable[k] &&
             destination_index[k*5 +: 5] == idx) begin
            d  = destination_data[k*XLEN +: XLEN];
            h  = 1'b1;
            hz = ~destination_data_ready[k];
         end
      end
   endfunction

   function automatic logic ref_stall();
      logic [XLEN-1:0] d;
      logic h, hz, any;
      any = 1'b0;
      for (int s = 0; s < int'(NSRC); s++) begin
         ref_fwd(s, d, h, hz);
         any |= hz;
      end
      return any;
   endfunction

   function automatic logic ref_any_hit();
      logic [XLEN-1:0] d;
      logic h, hz, any;
      any = 1'b0;
      for (int s = 0; s < int'(NSRC); s++) begin
         ref_fwd(s, d, h, hz);
         any |= h;
      end
      return any;
   endfunction

   // Advance one clock and the reference model; inputs change 1 time unit
   // after the edge so sampling never races the clock.
   task automatic tick();
      logic s, hit, r;
      s   = ref_stall();
      hit = ref_any_hit();
      r   = reset;
      @(posedge clk);
      if (r) begin
         run_len   = 0;
         m_fault   = 1'b0;
         m_timeout = 1'b0;
         m_resume  = 1'b0;
`ifdef HAZARD_PERF_COUNTERS_EN
         m_scc = 0;
         m_fc  = 0;
`endif
      end else begin
         m_resume = !m_fault && !s && run_len > 0;
         if (!m_fault) begin
            if (s) begin
               run_len++;
               if (run_len >= int'(MAXS)) begin
                  m_fault   = 1'b1;
                  m_timeout = 1'b1;
               end
            end else begin
               run_len = 0;
            end
         end
`ifdef HAZARD_PERF_COUNTERS_EN
         if (s && m_scc < 64'hFFFF_FFFF) m_scc++;
         if (!s && hit && m_fc < 64'hFFFF_FFFF) m_fc++;
`endif
      end
      #1;
   endtask

   task automatic idle();
      source_index             = '0;
      source_data              = '0;
      destination_index        = '0;
      destination_write_enable = '0;
      destination_data_ready   = '1;
      destination_data         = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (resume !== 1'b0) begin
         errors++;
         $display("FAIL reset_resume: got %b want 0", resume);
      end
      checks++;
      if (stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout: got %b want 0", stall_timeout);
      end
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall: got %b want 0", stall);
      end
`ifdef HAZARD_PERF_COUNTERS_EN
      checks++;
      if (stall_cycle_count !== 32'd0 || forward_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf: got %h/%h want 0/0", stall_cycle_count, forward_count);
      end
`endif
   endtask

   task automatic test_rf_fallback();
      idle();
      source_index            = {5'd7, 5'd5};
      source_data             = {32'h1111_2222, 32'h3333_4444};
      destination_index       = {5'd7, 5'd5, 5'd5};
      destination_data        = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
      destination_data_ready  = 3'b000;
      #1;
      checks++;
      if (forward_data !== {32'h1111_2222, 32'h3333_4444}) begin
         errors++;
         $display("FAIL rf_data: got %h want %h", forward_data, {32'h1111_2222, 32'h3333_4444});
      end
      checks++;
      if (forward_hit !== 2'b00 || stall !== 1'b0) begin
         errors++;
         $display("FAIL rf_hit_stall: got %b/%b want 00/0", forward_hit, stall);
      end
      tick();
   endtask

   task automatic test_priority();
      idle();
      source_index             = {5'd9, 5'd5};
      source_data              = {32'h0000_0009, 32'h0000_0005};
      destination_index        = {5'd5, 5'd9, 5'd5};
      destination_write_enable = 3'b111;
      destination_data_ready   = 3'b111;
      destination_data         = {32'h0000_BBBB, 32'hCCCC_CCCC, 32'hAAAA_0000};
      #1;
      checks++;
      if (forward_data[31:0] !== 32'hAAAA_0000 || forward_hit[0] !== 1'b1) begin
         errors++;
         $display("FAIL prio_src0: got %h/%b want aaaa0000/1", forward_data[31:0], forward_hit[0]);
      end
      checks++;
      if (forward_data[63:32] !== 32'hCCCC_CCCC || forward_hit[1] !== 1'b1) begin
         errors++;
         $display("FAIL prio_src1: got %h/%b want cccccccc/1", forward_data[63:32], forward_hit[1]);
      end
      // Younger not-ready writer must stall even though an older one is ready.
      destination_data_ready = 3'b110;
      #1;
      checks++;
      if (stall !== 1'b1 || forward_data[31:0] !== 32'hAAAA_0000) begin
         errors++;
         $display("FAIL prio_young_busy: got %b/%h want 1/aaaa0000", stall, forward_data[31:0]);
      end
      destination_data_ready = 3'b111;
      #1;
      tick();
   endtask

   task automatic test_x0();
      idle();
      source_index             = {5'd0, 5'd0};
      source_data              = {32'h5555_5555, 32'h1234_5678};
      destination_index        = {5'd0, 5'd0, 5'd0};
      destination_write_enable = 3'b111;
      destination_data_ready   = 3'b000;
      destination_data         = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      #1;
      checks++;
      if (forward_data[31:0] !== 32'h1234_5678 || forward_hit !== 2'b00 || stall !== 1'b0) begin
         errors++;
         $display("FAIL x0: got %h/%b/%b want 12345678/00/0", forward_data[31:0], forward_hit, stall);
      end
      tick();
   endtask

   task automatic test_load_use();
      idle();
      source_index             = {5'd1, 5'd3};
      source_data              = {32'h0, 32'h0000_0333};
      destination_index        = {5'd0, 5'd0, 5'd3};
      destination_write_enable = 3'b001;
      destination_data_ready   = 3'b000;
      destination_data         = {32'h0, 32'h0, 32'hC0DE_0003};
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall_c%0d: got %b want 1", c, stall);
         end
         tick();
      end
      destination_data_ready = 3'b001;
      #1;
      checks++;
      if (stall !== 1'b0 || forward_hit[0] !== 1'b1 || forward_data[31:0] !== 32'hC0DE_0003) begin
         errors++;
         $display("FAIL lu_ready: got %b/%b/%h want 0/1/c0de0003", stall, forward_hit[0],
                  forward_data[31:0]);
      end
      tick();
      checks++;
      if (resume !== 1'b1 || stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL lu_resume: got %b/%b want 1/0", resume, stall_timeout);
      end
      idle();
      tick();
      checks++;
      if (resume !== 1'b0) begin
         errors++;
         $display("FAIL lu_resume_once: got %b want 0", resume);
      end
   endtask

   task automatic test_timeout();
      idle();
      source_index             = {5'd0, 5'd4};
      destination_index        = {5'd0, 5'd4, 5'd0};
      destination_write_enable = 3'b010;
      destination_data_ready   = 3'b000;
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if (stall_timeout !== (e >= int'(MAXS)) || resume !== 1'b0) begin
            errors++;
            $display("FAIL to_edge%0d: got %b/%b want %b/0", e, stall_timeout, resume,
                     (e >= int'(MAXS)));
         end
      end
      // Hazard gone, but fault is terminal: no resume.
      destination_data_ready = 3'b111;
      tick();
      checks++;
      if (resume !== 1'b0 || stall_timeout !== 1'b1) begin
         errors++;
         $display("FAIL to_fault_hold: got %b/%b want 0/1", resume, stall_timeout);
      end
      // Reset mid-stall.
      destination_data_ready = 3'b000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (stall_timeout !== 1'b0 || resume !== 1'b0) begin
         errors++;
         $display("FAIL to_reset: got %b/%b want 0/0", stall_timeout, resume);
      end
      idle();
      tick();
      checks++;
      if (resume !== 1'b0) begin
         errors++;
         $display("FAIL to_no_resume_after_reset: got %b want 0", resume);
      end
   endtask

`ifdef HAZARD_PERF_COUNTERS_EN
   task automatic test_perf();
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
      source_index             = {5'd0, 5'd6};
      destination_index        = {5'd0, 5'd0, 5'd6};
      destination_write_enable = 3'b001;
      destination_data_ready   = 3'b000;
      for (int c = 0; c < 3; c++) tick();
      destination_data_ready = 3'b001;
      for (int c = 0; c < 5; c++) tick();
      idle();
      tick();
      checks++;
      if (stall_cycle_count !== 32'd3 || forward_count !== 32'd5) begin
         errors++;
         $display("FAIL perf_counts: got %0d/%0d want 3/5", stall_cycle_count, forward_count);
      end
   endtask
`endif

   task automatic test_random();
      logic [XLEN-1:0] ed;
      logic eh, ehz;
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 39) == 0);
         for (int s = 0; s < int'(NSRC); s++) begin
            source_index[s*5 +: 5]   = 5'($urandom_range(0, 3));
            source_data[s*XLEN +: XLEN] = $urandom();
         end
         for (int k = 0; k < int'(NSTG); k++) begin
            destination_index[k*5 +: 5]         = 5'($urandom_range(0, 3));
            destination_data[k*XLEN +: XLEN]    = $urandom();
            destination_write_enable[k]         = 1'($urandom_range(0, 1));
            destination_data_ready[k]           = ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int s = 0; s < int'(NSRC); s++) begin
            ref_fwd(s, ed, eh, ehz);
            checks++;
            if (forward_data[s*XLEN +: XLEN] !== ed || forward_hit[s] !== eh) begin
               errors++;
               $display("FAIL rnd_fwd n%0d s%0d: got %h/%b want %h/%b", n, s,
                        forward_data[s*XLEN +: XLEN], forward_hit[s], ed, eh);
            end
         end
         checks++;
         if (stall !== ref_stall()) begin
            errors++;
            $display("FAIL rnd_stall n%0d: got %b want %b", n, stall, ref_stall());
         end
         tick();
         checks++;
         if (resume !== m_resume || stall_timeout !== m_timeout) begin
            errors++;
            $display("FAIL rnd_fsm n%0d: got %b/%b want %b/%b", n, resume, stall_timeout,
                     m_resume, m_timeout);
         end
`ifdef HAZARD_PERF_COUNTERS_EN
         checks++;
         if (stall_cycle_count !== 32'(m_scc) || forward_count !== 32'(m_fc)) begin
            errors++;
            $display("FAIL rnd_perf n%0d: got %0d/%0d want %0d/%0d", n, stall_cycle_count,
                     forward_count, m_scc, m_fc);
         end
`endif
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #1;
      test_reset();
      test_rf_fallback();
      test_priority();
      test_x0();
      test_load_use();
      test_timeout();
`ifdef HAZARD_PERF_COUNTERS_EN
      test_perf();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
